restoring_divider_param: RTL and testbench



---
 rtl/restoring_divider_param.sv | 163 ++++++++++++++++
 tb/tb_restoring_divider_param.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_param.sv
// Parametrised restoring divider with valid/ready handshakes on both sides.
// Computes unsigned or signed (truncating) quotient and remainder, one
// quotient bit per clock, followed by a single sign-correction cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   in_valid    operand pair presented
//   in_ready    block can accept operands (high only while idle)
//   dividend    numerator, WIDTH bits
//   divisor     denominator, WIDTH bits
//   is_signed   1 = two's-complement operands, sampled with the operands
//   out_valid   result available
//   out_ready   consumer accepts result
//   quotient    quotient, WIDTH bits
//   remainder   remainder, WIDTH bits
//   div_by_zero divisor was zero for this result; qualified by out_valid
module restoring_divider_param #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  // Trial subtraction width: partial remainder (WIDTH+1) plus the shifted-in bit.
  localparam int unsigned RW    = WIDTH + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state, state_nxt;
  logic [WIDTH:0]   prem, prem_nxt;
  // Dividend magnitude shifts out of the top while quotient bits shift in.
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] dmag, dmag_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             neg_q, neg_q_nxt;
  logic             neg_r, neg_r_nxt;
  logic             in_ready_nxt, out_valid_nxt, div_by_zero_nxt;
  logic [WIDTH-1:0] quotient_nxt, remainder_nxt;
  logic [RW-1:0]    shifted, trial;
  logic             dvd_neg, dvs_neg;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nxt       = state;
    prem_nxt        = prem;
    acc_nxt         = acc;
    dmag_nxt        = dmag;
    cnt_nxt         = cnt;
    neg_q_nxt       = neg_q;
    neg_r_nxt       = neg_r;
    quotient_nxt    = quotient;
    remainder_nxt   = remainder;
    div_by_zero_nxt = div_by_zero;

    dvd_neg = is_signed & dividend[WIDTH-1];
    dvs_neg = is_signed & divisor[WIDTH-1];
    shifted = {prem, acc[WIDTH-1]};
    trial   = shifted - RW'(dmag);

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          neg_q_nxt = dvd_neg ^ dvs_neg;
          neg_r_nxt = dvd_neg;
          // Negation of the most-negative value yields itself, which is the
          // correct unsigned magnitude.
          acc_nxt   = dvd_neg ? -dividend : dividend;
          dmag_nxt  = dvs_neg ? -divisor : divisor;
          prem_nxt  = '0;
          cnt_nxt   = '0;
          if (divisor == '0) begin
            quotient_nxt    = '1;
            remainder_nxt   = dividend;
            div_by_zero_nxt = 1'b1;
            state_nxt       = DONE;
          end else begin
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        // Negative trial result restores the shifted remainder.
        if (trial[RW-1]) begin
          prem_nxt = shifted[WIDTH:0];
          acc_nxt  = {acc[WIDTH-2:0], 1'b0};
        end else begin
          prem_nxt = trial[WIDTH:0];
          acc_nxt  = {acc[WIDTH-2:0], 1'b1};
        end
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        quotient_nxt    = neg_q ? -acc : acc;
        remainder_nxt   = neg_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
        div_by_zero_nxt = 1'b0;
        state_nxt       = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      prem        <= '0;
      acc         <= '0;
      dmag        <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      prem        <= prem_nxt;
      acc         <= acc_nxt;
      dmag        <= dmag_nxt;
      cnt         <= cnt_nxt;
      neg_q       <= neg_q_nxt;
      neg_r       <= neg_r_nxt;
      in_ready    <= in_ready_nxt;
      out_valid   <= out_valid_nxt;
      quotient    <= quotient_nxt;
      remainder   <= remainder_nxt;
      div_by_zero <= div_by_zero_nxt;
    end
  end

endmodule

// File: tb/tb_restoring_divider_param.sv
// Bench for restoring_divider_param at WIDTH = 16, 8 and 32.
// Directed vectors with literal expectations on the 16-bit instance, random
// traffic on the 8- and 32-bit instances, and a per-cycle monitor that checks
// every instance against an arithmetic reference model.
module tb_restoring_divider_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  iv, sg, ordy;
  logic [63:0] dd [3];
  logic [63:0] ds [3];
  logic [2:0]  ir, ov, dz;
  logic [15:0] q16, r16;
  logic [7:0]  q8, r8;
  logic [31:0] q32, r32;
  logic [63:0] qo [3];
  logic [63:0] ro [3];

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          wid [3] = '{16, 8, 32};

  // Reference-model state per instance.
  logic        busy [3];
  logic        fresh [3];
  int unsigned valid_at [3];
  logic [63:0] eq [3];
  logic [63:0] er [3];
  logic        ez [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign qo[0] = 64'(q16);
  assign ro[0] = 64'(r16);
  assign qo[1] = 64'(q8);
  assign ro[1] = 64'(r8);
  assign qo[2] = 64'(q32);
  assign ro[2] = 64'(r32);

  restoring_divider_param #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .dividend(dd[0][15:0]), .divisor(ds[0][15:0]), .is_signed(sg[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .quotient(q16),
    .remainder(r16), .div_by_zero(dz[0]));

  restoring_divider_param #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .dividend(dd[1][7:0]), .divisor(ds[1][7:0]), .is_signed(sg[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .quotient(q8),
    .remainder(r8), .div_by_zero(dz[1]));

  restoring_divider_param #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .dividend(dd[2][31:0]), .divisor(ds[2][31:0]), .is_signed(sg[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .quotient(q32),
    .remainder(r32), .div_by_zero(dz[2]));

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference: truncating signed division, remainder takes
  // the dividend's sign; divide-by-zero returns all ones and the dividend.
  function automatic void model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                input logic s, output logic [63:0] q, output logic [63:0] r,
                                output logic z);
    logic [63:0] m, a, b;
    longint      sa, sb;
    m = (64'd1 << w) - 64'd1;
    a = a_in & m;
    b = b_in & m;
    z = 1'b0;
    if (b == 64'd0) begin
      q = m;
      r = a;
      z = 1'b1;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
      q  = 64'(sa / sb) & m;
      r  = 64'(sa % sb) & m;
    end
  endfunction

  task automatic pin(input int w, input logic [63:0] a, input logic [63:0] b, input logic s,
                     input logic [63:0] xq, input logic [63:0] xr, input logic xz, input string nm);
    logic [63:0] q, r;
    logic        z;
    model(w, a, b, s, q, r, z);
    cmp({"model ", nm, " q"}, q, xq);
    cmp({"model ", nm, " r"}, r, xr);
    cmp({"model ", nm, " dbz"}, 64'(z), 64'(xz));
  endtask

  // Per-cycle check of one instance against the model, then model update.
  task automatic check(input int k);
    logic  exp_ov;
    string tag;
    tag = $sformatf("w%0d", wid[k]);
    if (!rst) begin
      busy[k]  = 1'b0;
      fresh[k] = 1'b1;
      cmp({tag, " reset out_valid"}, 64'(ov[k]), 64'd0);
      cmp({tag, " reset quotient"}, qo[k], 64'd0);
      cmp({tag, " reset remainder"}, ro[k], 64'd0);
      cmp({tag, " reset dbz"}, 64'(dz[k]), 64'd0);
      return;
    end
    exp_ov = busy[k] && (cyc >= valid_at[k]);
    cmp({tag, " out_valid"}, 64'(ov[k]), 64'(exp_ov));
    cmp({tag, " in_ready"}, 64'(ir[k]), 64'(!busy[k]));
    if (exp_ov) begin
      fresh[k] = 1'b0;
      cmp({tag, " quotient"}, qo[k], eq[k]);
      cmp({tag, " remainder"}, ro[k], er[k]);
      cmp({tag, " dbz"}, 64'(dz[k]), 64'(ez[k]));
    end else if (fresh[k]) begin
      cmp({tag, " idle quotient"}, qo[k], 64'd0);
      cmp({tag, " idle remainder"}, ro[k], 64'd0);
    end
    if (!busy[k]) begin
      if (iv[k]) begin
        model(wid[k], dd[k], ds[k], sg[k], eq[k], er[k], ez[k]);
        busy[k]     = 1'b1;
        valid_at[k] = cyc + (ez[k] ? 1 : wid[k] + 2);
      end
    end else if (exp_ov && ordy[k]) begin
      busy[k] = 1'b0;
    end
  endtask

  // One directed transaction on the 16-bit instance with literal expectations.
  task automatic xact(input logic [63:0] a, input logic [63:0] b, input logic s,
                      input logic [63:0] xq, input logic [63:0] xr, input logic xz,
                      input int hold, input string nm);
    int t;
    @(posedge clk); #1;
    iv[0] = 1'b1; dd[0] = a; ds[0] = b; sg[0] = s; ordy[0] = (hold == 0);
    t = 0;
    @(negedge clk);
    while (!ir[0] && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    t = 0;
    @(negedge clk);
    while (!ov[0] && t < 100) begin @(negedge clk); t++; end
    cmp({nm, " out_valid seen"}, 64'(ov[0]), 64'd1);
    cmp({nm, " q"}, qo[0], xq);
    cmp({nm, " r"}, ro[0], xr);
    cmp({nm, " dbz"}, 64'(dz[0]), 64'(xz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      iv[0] = 1'b1; dd[0] = 64'($urandom); ds[0] = 64'($urandom);
      @(negedge clk);
      cmp({nm, " held in_ready"}, 64'(ir[0]), 64'd0);
      cmp({nm, " held q"}, qo[0], xq);
      cmp({nm, " held r"}, ro[0], xr);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      iv[0] = 1'b0; ordy[0] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cmp({nm, " post in_ready"}, 64'(ir[0]), 64'd1);
    cmp({nm, " post out_valid"}, 64'(ov[0]), 64'd0);
  endtask

  // Random operands with random out_ready on instance k.
  task automatic run_rand(input int k, input int n);
    logic [63:0] a, b;
    int          sel, t;
    logic        done;
    for (int i = 0; i < n; i++) begin
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      sel = $urandom_range(0, 7);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 64'd1 << (wid[k] - 1); b = '1; end
      else if (sel == 2) b = 64'($urandom_range(1, 9));
      @(posedge clk); #1;
      iv[k] = 1'b1; dd[k] = a; ds[k] = b; sg[k] = 1'($urandom_range(0, 1));
      t = 0;
      @(negedge clk);
      while (!ir[k] && t < 50) begin @(negedge clk); t++; end
      @(posedge clk); #1;
      iv[k] = 1'b0;
      done = 1'b0;
      t = 0;
      while (!done && t < 300) begin
        @(negedge clk);
        if (ov[k] && ordy[k]) done = 1'b1;
        else begin @(posedge clk); #1; ordy[k] = 1'($urandom_range(0, 1)); t++; end
      end
      if (!done) cmp($sformatf("w%0d handshake timeout", wid[k]), 64'd0, 64'd1);
      @(posedge clk);
    end
  endtask

  initial begin
    rst  = 1'b0;
    iv   = '0;
    sg   = '0;
    ordy = '1;
    for (int k = 0; k < 3; k++) begin
      dd[k] = '0; ds[k] = '0; busy[k] = 1'b0; fresh[k] = 1'b1;
      valid_at[k] = 0; eq[k] = '0; er[k] = '0; ez[k] = 1'b0;
    end

    pin(16, 64'd100, 64'd7, 1'b0, 64'h000E, 64'h0002, 1'b0, "100/7");
    pin(16, 64'hFF9C, 64'd7, 1'b1, 64'hFFF2, 64'hFFFE, 1'b0, "-100/7");
    pin(16, 64'd100, 64'hFFF9, 1'b1, 64'hFFF2, 64'h0002, 1'b0, "100/-7");
    pin(8, 64'h80, 64'hFF, 1'b1, 64'h80, 64'h00, 1'b0, "w8 ovf");
    pin(32, 64'hFFFFFF9C, 64'd7, 1'b1, 64'hFFFFFFF2, 64'hFFFFFFFE, 1'b0, "w32 -100/7");
    pin(8, 64'd200, 64'd0, 1'b1, 64'hFF, 64'hC8, 1'b1, "w8 div0");

    fork
      forever begin
        @(negedge clk);
        if (cyc > 0) for (int k = 0; k < 3; k++) check(k);
      end
    join_none

    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    xact(64'd100,   64'd7,     1'b0, 64'h000E, 64'h0002, 1'b0, 0, "u 100/7");
    xact(64'hFF9C,  64'd7,     1'b1, 64'hFFF2, 64'hFFFE, 1'b0, 0, "s -100/7");
    xact(64'hFF9C,  64'hFFF9,  1'b1, 64'h000E, 64'hFFFE, 1'b0, 0, "s -100/-7");
    xact(64'hFFFF,  64'h0001,  1'b0, 64'hFFFF, 64'h0000, 1'b0, 0, "u FFFF/1");
    xact(64'h04D2,  64'h0000,  1'b0, 64'hFFFF, 64'h04D2, 1'b1, 0, "u div0");
    xact(64'h04D2,  64'h0000,  1'b1, 64'hFFFF, 64'h04D2, 1'b1, 0, "s div0");
    xact(64'h8000,  64'hFFFF,  1'b1, 64'h8000, 64'h0000, 1'b0, 0, "s ovf");
    xact(64'h8000,  64'h0002,  1'b1, 64'hC000, 64'h0000, 1'b0, 0, "s 8000/2");
    xact(64'd1234,  64'd10,    1'b0, 64'd123,  64'd4,    1'b0, 5, "backpressure");

    // Abort a transaction after the eighth CALC iteration.
    @(posedge clk); #1;
    iv[0] = 1'b1; dd[0] = 64'd5000; ds[0] = 64'd3; sg[0] = 1'b0; ordy[0] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cmp("midop reset out_valid", 64'(ov[0]), 64'd0);
    cmp("midop reset q", qo[0], 64'd0);
    cmp("midop reset r", ro[0], 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    cmp("midop release in_ready", 64'(ir[0]), 64'd1);
    cmp("midop release out_valid", 64'(ov[0]), 64'd0);
    xact(64'd1000, 64'd33, 1'b0, 64'd30, 64'd10, 1'b0, 0, "after reset 1000/33");

    fork
      run_rand(1, 40);
      run_rand(2, 40);
    join

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
